tile_scheduler: RTL and testbench
=================================

# tile_scheduler

Sequences one layer's tiled execution over the GLB and PE datapath. It latches the layer configuration and the `tile_n` value produced by the tile-size calculator, then walks the output-channel, spatial and input-channel tile loops. For every tile it issues weight-load, ifmap-load, compute and psum-store commands through req/ack handshakes, and publishes the current tile's base and length to the DMA and PE controller.

## Interface
Parameters:
- `CH_W`, default 7: channel and tile-channel width.
- `N_W`, default 32: spatial count width, matching `tile_n`.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: layer start pulse. Accepted only in IDLE.
- `layer_type`  in  2: 0=PW, 1=DW, 2=STD, 3=LIN.
- `in_C`, `out_C`  in  CH_W: layer channel counts.
- `tile_D`, `tile_K`  in  CH_W: input- and output-channel tile sizes.
- `tile_n`  in  N_W: spatial tile size from the tile-size calculator.
- `total_n`  in  N_W: output spatial positions in the layer.
- `ld_w_req`/`ld_w_ack`  out/in  1: weight-load handshake.
- `ld_i_req`/`ld_i_ack`  out/in  1: ifmap-load handshake.
- `cmp_req`/`cmp_ack`  out/in  1: compute handshake. `cmp_ack` signals compute done.
- `st_p_req`/`st_p_ack`  out/in  1: psum store to DRAM.
- `acc_first`  out  1: current compute is the first d-tile, so the PE loads bias and does not accumulate.
- `k_base`, `k_len`, `d_base`, `d_len`  out  CH_W: current channel window.
- `n_base`, `n_len`  out  N_W: current spatial window.
- `busy`  out  1: high from the cycle after `start` is accepted until `done`.
- `done`  out  1: one-cycle pulse at layer completion.
- `err`  out  1: sticky bad-configuration flag. Cleared by the next accepted `start`.

## Operation
- `start` in IDLE latches all configuration inputs. Later changes to the inputs are ignored until the next IDLE.
- Loop order:
  - k is the outermost loop, over `out_C` in steps of `tile_K`.
  - n is the middle loop, over `total_n` in steps of `tile_n`.
  - d is the innermost loop, over `in_C` in steps of `tile_D`.
- Length of each window:
  - `len = min(step, total - base)`, so the last tile of each loop is partial.
  - A loop is on its last tile when `base + step >= total`.
- DW layers have no d loop:
  - `d_base = k_base` and `d_len = k_len`.
  - There is exactly one d iteration.
- State machine:
  - IDLE→CHECK on `start`.
  - CHECK→ERR if any of `tile_K`, `tile_D`, `tile_n`, `out_C`, `in_C`, `total_n` is 0. Otherwise CHECK→LD_W.
  - LD_W→LD_I on `ld_w_ack`.
  - LD_I→CMP on `ld_i_ack`.
  - CMP on `cmp_ack`:
    - If d is not last: advance d, go to LD_W.
    - Else go to ST.
  - ST on `st_p_ack`:
    - Reset d to 0.
    - If n is not last: advance n, go to LD_W.
    - Else if k is not last: reset n to 0, advance k, go to LD_W.
    - Else go to DONE.
  - DONE→IDLE after one cycle, with `done`=1 during that cycle.
  - ERR→IDLE after one cycle, with `err` set and `done`=1 during that cycle.
- `acc_first` = (`d_base` == 0). It is valid in all states.
- Base and length outputs change only on the state transition that advances a counter. They are stable for the whole handshake that uses them.
- Arithmetic:
  - Base additions are computed one bit wider than the operand width.
  - The carry is treated as "past total", so a base near the width maximum must not wrap.

## Timing
- Reset values:
  - All reqs = 0, `busy` = 0, `done` = 0, `err` = 0.
  - All bases and lengths = 0.
  - State = IDLE.
- `start` is sampled in cycle t. `ld_w_req` rises in cycle t+2 (one cycle spent in CHECK).
- Each req is registered and rises on state entry. It stays high until the ack is sampled high, and falls in the next cycle.
- An ack while its req is low is ignored.
- There is zero idle cycles between handshakes: the next req is asserted in the cycle after the previous ack.
- `start` while not in IDLE is ignored.
- Reset asserted mid-layer:
  - All outputs clear immediately, because reset is asynchronous.
  - No pending req survives reset.

## Configuration
- With `TILE_SCHED_PERF_EN` defined, the block adds three outputs:
  - `perf_busy_cyc`: 32-bit count of cycles with `busy` high.
  - `perf_stall_cyc`: 32-bit count of cycles with any req high and its ack low.
  - `perf_tiles`: 32-bit count of `cmp_ack` events.
- All three counters clear on an accepted `start` and saturate at all-ones.
- Without `TILE_SCHED_PERF_EN`, these ports and their logic do not exist.

## Structure
- Shared package `tile_sched_pkg` holds:
  - The `sched_state_e` enum (IDLE, CHECK, LD_W, LD_I, CMP, ST, DONE, ERR).
  - The layer-type constants.
- One sub-module, `tile_loop_cnt`, parameterized by width. Instanced three times, once each for k, n and d.
  - Inputs: `clr`, `adv`, `step`, `total`.
  - Outputs: `base`, `len`, `last`.

## Test plan
- PW: `in_C`=32, `out_C`=64, `tile_D`=16, `tile_K`=32, `total_n`=100, `tile_n`=40, all acks 1 cycle after req.
  - Expect 12 compute handshakes and 6 stores.
  - Expect `n_len` sequence 40, 40, 20.
  - `acc_first` is high on alternate computes.
  - One `done` pulse.
- DW: `in_C`=`out_C`=20, `tile_K`=8, `total_n`=16, `tile_n`=16.
  - Expect 3 k tiles with `k_len`/`d_len` 8, 8, 4.
  - `d_base`==`k_base` for every tile.
  - Expect 3 stores.
- `tile_n`=0 → ERR path:
  - No req ever asserted.
  - `err`=1 and a `done` pulse 2 cycles after `start`.
- Ack backpressure: `ld_i_ack` delayed 5 cycles.
  - `ld_i_req` stays high for 6 cycles.
  - `n_base` and `d_base` are stable throughout.
  - A spurious `cmp_ack` during LD_I is ignored.
- `rst_n` dropped during CMP of the 2nd tile.
  - All outputs return to 0 asynchronously.
  - A fresh `start` reruns the layer from `k_base`=`n_base`=`d_base`=0.
- With `TILE_SCHED_PERF_EN`, using the PW case with 1-cycle acks:
  - `perf_tiles`=12.
  - `perf_stall_cyc` = the number of req-high cycles with ack low.

Source files
------------

// File: rtl/tile_sched_pkg.sv
// rtl/tile_sched_pkg.sv - shared state encoding and layer-type constants for the tile scheduler
package tile_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LD_W,
        LD_I,
        CMP,
        ST,
        DONE,
        ERR
    } sched_state_e;

    localparam logic [1:0] LT_PW  = 2'd0;
    localparam logic [1:0] LT_DW  = 2'd1;
    localparam logic [1:0] LT_STD = 2'd2;
    localparam logic [1:0] LT_LIN = 2'd3;

endpackage

// File: rtl/tile_loop_cnt.sv
// rtl/tile_loop_cnt.sv - one tiled loop level: registered base/len window, combinational last-tile flag
module tile_loop_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         adv,
    input  logic [W-1:0] step,
    input  logic [W-1:0] total,
    output logic [W-1:0] base,
    output logic [W-1:0] len,
    output logic         last
);

    logic [W:0]   next_sum;
    logic [W-1:0] next_base;

    // One extra bit so a base near the width maximum reads as past total instead of wrapping.
    assign next_sum  = {1'b0, base} + {1'b0, step};
    assign next_base = next_sum[W-1:0];
    assign last      = (next_sum >= {1'b0, total});

    function automatic logic [W-1:0] win_len(input logic [W-1:0] b, input logic [W-1:0] s,
                                             input logic [W-1:0] t);
        logic [W-1:0] rem;
        rem = t - b;
        return (s < rem) ? s : rem;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= '0;
            len  <= '0;
        end else if (clr) begin
            base <= '0;
            len  <= win_len('0, step, total);
        end else if (adv && !last) begin
            base <= next_base;
            len  <= win_len(next_base, step, total);
        end
    end

endmodule

// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - k/n/d tile loop sequencer issuing load/compute/store handshakes.
// Optional perf counters are built when TILE_SCHED_PERF_EN is defined.
module tile_scheduler
    import tile_sched_pkg::*;
#(
    parameter int CH_W = 7,
    parameter int N_W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      layer_type,
    input  logic [CH_W-1:0] in_C,
    input  logic [CH_W-1:0] out_C,
    input  logic [CH_W-1:0] tile_D,
    input  logic [CH_W-1:0] tile_K,
    input  logic [N_W-1:0]  tile_n,
    input  logic [N_W-1:0]  total_n,
    output logic            ld_w_req,
    input  logic            ld_w_ack,
    output logic            ld_i_req,
    input  logic            ld_i_ack,
    output logic            cmp_req,
    input  logic            cmp_ack,
    output logic            st_p_req,
    input  logic            st_p_ack,
    output logic            acc_first,
    output logic [CH_W-1:0] k_base,
    output logic [CH_W-1:0] k_len,
    output logic [CH_W-1:0] d_base,
    output logic [CH_W-1:0] d_len,
    output logic [N_W-1:0]  n_base,
    output logic [N_W-1:0]  n_len,
    output logic            busy,
    output logic            done,
    output logic            err
`ifdef TILE_SCHED_PERF_EN
    ,
    output logic [31:0]     perf_busy_cyc,
    output logic [31:0]     perf_stall_cyc,
    output logic [31:0]     perf_tiles
`endif
);

    sched_state_e    state;
    logic [1:0]      cfg_type;
    logic [CH_W-1:0] cfg_in_c, cfg_out_c, cfg_tile_d, cfg_tile_k;
    logic [N_W-1:0]  cfg_tile_n, cfg_total_n;

    logic            is_dw, cfg_bad;
    logic            start_acc, cmp_fire, st_fire;
    logic            k_last, n_last, d_cnt_last, d_last;
    logic            k_adv, n_adv, d_adv, n_clr, d_clr, cnt_clr;
    logic [CH_W-1:0] d_cnt_base, d_cnt_len;

    assign is_dw     = (cfg_type == LT_DW);
    assign cfg_bad   = (cfg_tile_k == '0) || (cfg_tile_d == '0) || (cfg_tile_n == '0) ||
                       (cfg_out_c == '0) || (cfg_in_c == '0) || (cfg_total_n == '0);
    assign start_acc = (state == IDLE) && start;
    assign cmp_fire  = (state == CMP) && cmp_req && cmp_ack;
    assign st_fire   = (state == ST) && st_p_req && st_p_ack;

    // Depthwise layers run a single d pass that mirrors the k window.
    assign d_last  = is_dw || d_cnt_last;
    assign cnt_clr = (state == CHECK);
    assign d_adv   = cmp_fire && !d_last;
    assign d_clr   = cnt_clr || st_fire;
    assign n_adv   = st_fire && !n_last;
    assign k_adv   = st_fire && n_last && !k_last;
    assign n_clr   = cnt_clr || k_adv;

    tile_loop_cnt #(.W(CH_W)) u_k_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .adv   (k_adv),
        .step  (cfg_tile_k),
        .total (cfg_out_c),
        .base  (k_base),
        .len   (k_len),
        .last  (k_last)
    );

    tile_loop_cnt #(.W(N_W)) u_n_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (n_clr),
        .adv   (n_adv),
        .step  (cfg_tile_n),
        .total (cfg_total_n),
        .base  (n_base),
        .len   (n_len),
        .last  (n_last)
    );

    tile_loop_cnt #(.W(CH_W)) u_d_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (d_clr),
        .adv   (d_adv),
        .step  (cfg_tile_d),
        .total (cfg_in_c),
        .base  (d_cnt_base),
        .len   (d_cnt_len),
        .last  (d_cnt_last)
    );

    assign d_base    = is_dw ? k_base : d_cnt_base;
    assign d_len     = is_dw ? k_len  : d_cnt_len;
    assign acc_first = (d_base == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ld_w_req    <= 1'b0;
            ld_i_req    <= 1'b0;
            cmp_req     <= 1'b0;
            st_p_req    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cfg_type    <= '0;
            cfg_in_c    <= '0;
            cfg_out_c   <= '0;
            cfg_tile_d  <= '0;
            cfg_tile_k  <= '0;
            cfg_tile_n  <= '0;
            cfg_total_n <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cfg_type    <= layer_type;
                        cfg_in_c    <= in_C;
                        cfg_out_c   <= out_C;
                        cfg_tile_d  <= tile_D;
                        cfg_tile_k  <= tile_K;
                        cfg_tile_n  <= tile_n;
                        cfg_total_n <= total_n;
                        err         <= 1'b0;
                        busy        <= 1'b1;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (cfg_bad) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERR;
                    end else begin
                        ld_w_req <= 1'b1;
                        state    <= LD_W;
                    end
                end
                LD_W: begin
                    if (ld_w_req && ld_w_ack) begin
                        ld_w_req <= 1'b0;
                        ld_i_req <= 1'b1;
                        state    <= LD_I;
                    end
                end
                LD_I: begin
                    if (ld_i_req && ld_i_ack) begin
                        ld_i_req <= 1'b0;
                        cmp_req  <= 1'b1;
                        state    <= CMP;
                    end
                end
                CMP: begin
                    if (cmp_fire) begin
                        cmp_req <= 1'b0;
                        if (!d_last) begin
                            ld_w_req <= 1'b1;
                            state    <= LD_W;
                        end else begin
                            st_p_req <= 1'b1;
                            state    <= ST;
                        end
                    end
                end
                ST: begin
                    if (st_fire) begin
                        st_p_req <= 1'b0;
                        if (!n_last || !k_last) begin
                            ld_w_req <= 1'b1;
                            state    <= LD_W;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TILE_SCHED_PERF_EN
    logic stall;

    assign stall = (ld_w_req && !ld_w_ack) || (ld_i_req && !ld_i_ack) ||
                   (cmp_req && !cmp_ack) || (st_p_req && !st_p_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
            perf_tiles     <= '0;
        end else if (start_acc) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
            perf_tiles     <= '0;
        end else begin
            if (busy && (perf_busy_cyc != '1))
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            if (stall && (perf_stall_cyc != '1))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (cmp_fire && (perf_tiles != '1))
                perf_tiles <= perf_tiles + 32'd1;
        end
    end
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - self-checking bench: loop-nest transaction model plus directed layer cases
module tb_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [1:0]  layer_type;
    logic [6:0]  in_C, out_C, tile_D, tile_K;
    logic [31:0] tile_n, total_n;
    logic        ld_w_ack, ld_i_ack, cmp_ack, st_p_ack;
    logic        ld_w_req, ld_i_req, cmp_req, st_p_req, acc_first, busy, done, err;
    logic [6:0]  k_base, k_len, d_base, d_len;
    logic [31:0] n_base, n_len;
`ifdef TILE_SCHED_PERF_EN
    logic [31:0] perf_busy_cyc, perf_stall_cyc, perf_tiles;
`endif

    always #5 clk = ~clk;

    tile_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer_type(layer_type),
        .in_C(in_C), .out_C(out_C), .tile_D(tile_D), .tile_K(tile_K),
        .tile_n(tile_n), .total_n(total_n),
        .ld_w_req(ld_w_req), .ld_w_ack(ld_w_ack), .ld_i_req(ld_i_req), .ld_i_ack(ld_i_ack),
        .cmp_req(cmp_req), .cmp_ack(cmp_ack), .st_p_req(st_p_req), .st_p_ack(st_p_ack),
        .acc_first(acc_first), .k_base(k_base), .k_len(k_len), .d_base(d_base), .d_len(d_len),
        .n_base(n_base), .n_len(n_len), .busy(busy), .done(done), .err(err)
`ifdef TILE_SCHED_PERF_EN
        , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc), .perf_tiles(perf_tiles)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // op: 0 weight load, 1 ifmap load, 2 compute, 3 psum store
    typedef struct {
        int     op;
        int     kb, kl, db, dl;
        longint nb, nl;
        bit     acc;
    } ev_t;

    ev_t evq[$];
    ev_t obs[$];

    function automatic longint lmin(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [127:0] pack(input ev_t e);
        return {35'b0, 7'(e.kb), 7'(e.kl), 7'(e.db), 7'(e.dl), 32'(e.nb), 32'(e.nl), e.acc};
    endfunction

    function automatic void build_model(input int lt, input int ic, input int oc, input int td,
                                        input int tk, input longint tn, input longint totn);
        ev_t e;
        evq.delete();
        for (int kb = 0; kb < oc; kb += tk) begin
            for (longint nb = 0; nb < totn; nb += tn) begin
                e.kb = kb;
                e.kl = int'(lmin(tk, oc - kb));
                e.nb = nb;
                e.nl = lmin(tn, totn - nb);
                if (lt == 1) begin
                    e.db = e.kb;
                    e.dl = e.kl;
                    e.acc = (e.db == 0);
                    for (int o = 0; o < 3; o++) begin e.op = o; evq.push_back(e); end
                end else begin
                    for (int db = 0; db < ic; db += td) begin
                        e.db = db;
                        e.dl = int'(lmin(td, ic - db));
                        e.acc = (db == 0);
                        for (int o = 0; o < 3; o++) begin e.op = o; evq.push_back(e); end
                    end
                end
                e.op = 3;
                evq.push_back(e);
            end
        end
    endfunction

    function automatic int count_op(input int op);
        int c = 0;
        foreach (obs[i]) if (obs[i].op == op) c++;
        return c;
    endfunction

    function automatic ev_t nth_op(input int op, input int n);
        ev_t z;
        int c = 0;
        z = '{default: 0};
        foreach (obs[i]) if (obs[i].op == op) begin
            if (c == n) return obs[i];
            c++;
        end
        return z;
    endfunction

    // Ack responder: ack rises dly cycles after req rises, so req stays high dly+1 cycles.
    int         dly[4];
    int         rcnt[4];
    logic [3:0] ackr;
    logic       cmp_spur;
    bit         spur_en;
    assign ld_w_ack = ackr[0];
    assign ld_i_ack = ackr[1];
    assign cmp_ack  = ackr[2] | cmp_spur;
    assign st_p_ack = ackr[3];

    always @(posedge clk) begin
        logic [3:0] rq;
        #1;
        rq = {st_p_req, cmp_req, ld_i_req, ld_w_req};
        if (!rst_n) begin
            ackr = '0;
            cmp_spur = 1'b0;
            for (int i = 0; i < 4; i++) rcnt[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ackr[i]) begin
                    ackr[i] = 1'b0;
                    rcnt[i] = 0;
                end else if (rq[i]) begin
                    rcnt[i]++;
                    if (rcnt[i] == dly[i] + 1) ackr[i] = 1'b1;
                end
            end
            cmp_spur = spur_en && ld_i_req && (rcnt[1] == 2);
        end
    end

    // Transaction-level model: 0 idle, 1 config check, 2 walking evq, 3 done cycle.
    int         phase = 0;
    int         idx = 0;
    bit         m_err = 0, m_bad = 0;
    int         cyc = 0, start_cyc = 0, done_cyc = 0, n_done = 0, n_cmp = 0;
    int         req_cycles = 0, stall_cnt = 0, busy_cnt = 0;
    int         run_w = 0, run_i = 0, max_w = 0, max_i = 0;
    logic [3:0] req_v, ack_v, ereq;
    ev_t        o;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            phase = 0;
            m_err = 0;
        end else begin
            req_v = {st_p_req, cmp_req, ld_i_req, ld_w_req};
            ack_v = {st_p_ack, cmp_ack, ld_i_ack, ld_w_ack};
            ereq = (phase == 2) ? 4'(1 << evq[idx].op) : 4'b0;
            chk("reqs", 128'(req_v), 128'(ereq));
            chk("busy_done_err", 128'({busy, done, err}),
                128'({(phase == 1) || (phase == 2), phase == 3, m_err}));
            if (phase == 2)
                chk("window", 128'({k_base, k_len, d_base, d_len, n_base, n_len, acc_first}),
                    pack(evq[idx]));
            for (int i = 0; i < 4; i++) if (req_v[i] && ack_v[i]) begin
                o.op = i; o.kb = k_base; o.kl = k_len; o.db = d_base; o.dl = d_len;
                o.nb = n_base; o.nl = n_len; o.acc = acc_first;
                obs.push_back(o);
                if (i == 2) n_cmp++;
            end
            if (done) begin n_done++; done_cyc = cyc; end
            if (req_v != 0) req_cycles++;
            if ((req_v & ~ack_v) != 0) stall_cnt++;
            if ((phase == 1) || (phase == 2)) busy_cnt++;
            run_w = ld_w_req ? run_w + 1 : 0;
            run_i = ld_i_req ? run_i + 1 : 0;
            if (run_w > max_w) max_w = run_w;
            if (run_i > max_i) max_i = run_i;
            case (phase)
                0: if (start) begin
                    phase = 1; m_err = 0; start_cyc = cyc;
                    stall_cnt = 0; busy_cnt = 0; n_cmp = 0;
                    m_bad = (tile_K == 0) || (tile_D == 0) || (tile_n == 0) ||
                            (out_C == 0) || (in_C == 0) || (total_n == 0);
                    if (!m_bad) build_model(layer_type, in_C, out_C, tile_D, tile_K, tile_n, total_n);
                end
                1: if (m_bad) begin phase = 3; m_err = 1; end
                   else begin phase = 2; idx = 0; end
                2: if (ack_v[evq[idx].op]) begin
                    idx++;
                    if (idx == evq.size()) phase = 3;
                end
                default: phase = 0;
            endcase
        end
    end

    task automatic pulse_start(input int lt, input int ic, input int oc, input int td, input int tk,
                               input logic [31:0] tn, input logic [31:0] totn);
        @(posedge clk); #1;
        layer_type = 2'(lt); in_C = 7'(ic); out_C = 7'(oc); tile_D = 7'(td); tile_K = 7'(tk);
        tile_n = tn; total_n = totn;
        obs.delete(); n_done = 0; req_cycles = 0; max_w = 0; max_i = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs: the layer must keep running on the latched copy.
        in_C = 7'h55; out_C = 7'h3; tile_D = 7'h1; tile_K = 7'h2; tile_n = 32'd7; layer_type = 2'd2;
    endtask

    task automatic run_layer(input string name, input int lt, input int ic, input int oc,
                             input int td, input int tk, input logic [31:0] tn,
                             input logic [31:0] totn, input bit mid_start);
        pulse_start(lt, ic, oc, td, tk, tn, totn);
        for (int c = 0; c < 3000 && n_done == 0; c++) begin
            @(posedge clk); #1;
            start = mid_start && (c == 20);
        end
        start = 1'b0;
        chk({name, "_done_count"}, 128'(n_done), 128'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; layer_type = '0;
        in_C = '0; out_C = '0; tile_D = '0; tile_K = '0; tile_n = '0; total_n = '0;
        for (int i = 0; i < 4; i++) dly[i] = 1;
        spur_en = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 128'({ld_w_req, ld_i_req, cmp_req, st_p_req, busy, done, err,
                                   k_base, k_len, d_base, d_len, n_base, n_len}), 128'd0);
        chk("reset_acc_first", 128'(acc_first), 128'd1);
        rst_n = 1'b1;

        // PW: 2 k x 3 n x 2 d tiles
        run_layer("pw", 0, 32, 64, 16, 32, 32'd40, 32'd100, 0);
        chk("pw_model_events", 128'(evq.size()), 128'd42);
        chk("pw_computes", 128'(count_op(2)), 128'd12);
        chk("pw_stores", 128'(count_op(3)), 128'd6);
        chk("pw_nlen0", 128'(nth_op(3, 0).nl), 128'd40);
        chk("pw_nlen1", 128'(nth_op(3, 1).nl), 128'd40);
        chk("pw_nlen2", 128'(nth_op(3, 2).nl), 128'd20);
        for (int i = 0; i < 12; i++)
            chk($sformatf("pw_acc_first_%0d", i), 128'(nth_op(2, i).acc), 128'(i % 2 == 0));
`ifdef TILE_SCHED_PERF_EN
        chk("perf_tiles", 128'(perf_tiles), 128'd12);
        chk("perf_stall_model", 128'(stall_cnt), 128'd42);
        chk("perf_stall", 128'(perf_stall_cyc), 128'(stall_cnt));
        chk("perf_busy", 128'(perf_busy_cyc), 128'(busy_cnt));
`endif

        // DW: k windows 8,8,4 mirrored onto d
        run_layer("dw", 1, 20, 20, 4, 8, 32'd16, 32'd16, 0);
        chk("dw_computes", 128'(count_op(2)), 128'd3);
        chk("dw_stores", 128'(count_op(3)), 128'd3);
        chk("dw_klen0", 128'({nth_op(3, 0).kl, nth_op(3, 0).dl}), 128'({32'd8, 32'd8}));
        chk("dw_klen1", 128'({nth_op(3, 1).kl, nth_op(3, 1).dl}), 128'({32'd8, 32'd8}));
        chk("dw_klen2", 128'({nth_op(3, 2).kl, nth_op(3, 2).dl}), 128'({32'd4, 32'd4}));
        for (int i = 0; i < 3; i++)
            chk($sformatf("dw_dbase_%0d", i), 128'(nth_op(2, i).db), 128'(8 * i));

        // STD with partial d tiles 4,4,2
        run_layer("std", 2, 10, 5, 4, 8, 32'd3, 32'd7, 0);
        chk("std_computes", 128'(count_op(2)), 128'd9);
        chk("std_dlen2", 128'(nth_op(2, 2).dl), 128'd2);
        chk("std_nlen_last", 128'(nth_op(3, 2).nl), 128'd1);

        // Spatial base near the 32-bit maximum must not wrap
        run_layer("wide", 3, 1, 1, 1, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
        chk("wide_computes", 128'(count_op(2)), 128'd2);
        chk("wide_nbase1", 128'(nth_op(2, 1).nb), 128'hFFFF_FFFE);
        chk("wide_nlen1", 128'(nth_op(2, 1).nl), 128'd1);

        // Zero tile_n: error path
        run_layer("err", 0, 32, 64, 16, 32, 32'd0, 32'd100, 0);
        chk("err_no_req", 128'(req_cycles), 128'd0);
        chk("err_done_latency", 128'(done_cyc - start_cyc), 128'd2);
        chk("err_sticky", 128'(err), 128'd1);

        // Backpressure on ifmap load, spurious compute ack, ignored mid-layer start
        dly[1] = 5;
        spur_en = 1;
        run_layer("bp", 0, 32, 64, 16, 32, 32'd40, 32'd100, 1);
        chk("bp_ld_i_high", 128'(max_i), 128'd6);
        chk("bp_ld_w_high", 128'(max_w), 128'd2);
        chk("bp_computes", 128'(count_op(2)), 128'd12);
        dly[1] = 1;
        spur_en = 0;

        // Asynchronous reset during the second compute
        pulse_start(0, 32, 64, 16, 32, 32'd40, 32'd100);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (cmp_req && n_cmp == 1) break;
        end
        #2;
        chk("rst_in_cmp2", 128'({cmp_req, 32'(n_cmp)}), 128'({1'b1, 32'd1}));
        rst_n = 1'b0;
        #1;
        chk("rst_async_clear", 128'({ld_w_req, ld_i_req, cmp_req, st_p_req, busy, done, err,
                                     k_base, k_len, d_base, d_len, n_base, n_len}), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_layer("rerun", 0, 32, 64, 16, 32, 32'd40, 32'd100, 0);
        chk("rerun_first_bases", 128'({obs[0].kb, 32'(obs[0].nb), obs[0].db}), 128'd0);
        chk("rerun_computes", 128'(count_op(2)), 128'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
